dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle data memory in the MIPS core.
- Byte-addressed word memory with byte, halfword and word loads and stores, sign or zero extension on loads, and a registered one-cycle read.
- valid/ready request interface; a response pulse is returned for every accepted request.
- Power-on clear state machine zeroes the array after every reset. Sits between the core's MEM stage and the data bus.

Parameters:
ADDR_W, 11, byte-address width; must be at least 2 + log2(DEPTH)
DEPTH, 32, number of 32-bit words; power of two, at least 2
IDX_W, log2(DEPTH), derived word-index width (localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
req_unsigned  in  1  load zero-extends when 1; ignored for stores and word loads
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  misaligned access (see Optional Feature)
init_done  out  1  high once the clear sequence has finished

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, clear counter=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
- INIT state:
  - Each cycle writes 0 to word[counter], then increments the counter.
  - After writing word DEPTH-1, goes to RUN. INIT takes exactly DEPTH cycles after reset release.
  - req_ready=0 throughout INIT.
- RUN state:
  - req_ready=1 and init_done=1 permanently until the next reset.
  - No output backpressure.
- Accept: a request is accepted when req_valid and req_ready are both high at a rising edge.
- Word index: req_addr[IDX_W+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH.
- Lanes are little-endian:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
- Store:
  - Only the addressed lanes are written, at the accept edge. Other lanes are untouched.
  - rsp_valid=1 on the next cycle with rsp_rdata=0.
- Load:
  - The array is read at the accept edge. The lane is extracted and sign-extended (or zero-extended when req_unsigned=1) into rsp_rdata.
  - rsp_valid=1 on the next cycle. Latency is exactly 1.
- Back-to-back requests are accepted every cycle. Responses appear in order, one per accepted request.
- Write at edge N followed by a load of the same word accepted at edge N+1 returns the new data (no forwarding needed).
- With no accept, rsp_valid=0 next cycle. rsp_rdata and rsp_err hold their last value.
- Reset mid-operation:
  - Outputs drop immediately; any pending response is discarded.
  - INIT restarts from word 0, and array contents are cleared again.
- Read-during-clear is impossible because req_ready=0 during INIT.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: a misaligned access (half with addr[0]=1, word/reserved with addr[1:0]!=0) is still accepted.
  - Stores do not modify memory.
  - The response next cycle has rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Undefined:
  - Misaligned low address bits are forced to 0 (half ignores addr[0], word ignores addr[1:0]) and the access proceeds normally.
  - rsp_err is tied to 0.

Test Plan:
1. Release rst_n -> req_ready/init_done stay 0 for exactly 32 cycles, then rise; first lw 0x7C -> rsp_valid next cycle, rsp_rdata 0x00000000.
2. sw 0x10 <- 0x8899AABB, then lw 0x10 back-to-back -> rsp_rdata 0x8899AABB one cycle after accept; lw 0x90 (alias) -> 0x8899AABB.
3. sb 0x11 <- 0x000000FF; lb 0x11 -> 0xFFFFFFFF; lbu 0x11 -> 0x000000FF; lw 0x10 -> 0x8899FFBB.
4. lh 0x12 -> 0xFFFF8899; lhu 0x12 -> 0x00008899; sh 0x12 <- 0x1234, then lw 0x10 -> 0x1234FFBB.
5. With macro: lw 0x13 -> rsp_err=1, rdata 0; sw 0x13 <- 0xDEADBEEF then lw 0x10 unchanged. Without macro: lw 0x13 returns the word at 0x10, rsp_err=0.
6. sw 0x10 <- 0xCAFEF00D, pulse rst_n low while a load is in flight -> rsp_valid 0 immediately, no response; after 32 INIT cycles lw 0x10 -> 0x00000000.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with byte/half/word access, registered one-cycle responses and a power-on clear.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_nx;
  logic             req_ready_nx, init_done_nx, rsp_valid_nx, rsp_err_nx;
  logic [31:0]      rsp_rdata_nx;

  logic [31:0]      mem [DEPTH];

  logic             accept_c;
  logic [IDX_W-1:0] idx_c;
  logic [1:0]       off_c;
  logic [3:0]       be_c;
  logic [31:0]      wd_c;
  logic             err_c;
  logic             wr_en_c;
  logic [31:0]      rd_word_c;
  logic [31:0]      sh_c;
  logic [31:0]      ld_c;

  // Address decode, lane enables and load extraction for the current request.
  always_comb begin
    accept_c = req_valid & req_ready;
    idx_c    = req_addr[IDX_W+1:2];
    case (req_size)
      2'b00:   off_c = req_addr[1:0];
      2'b01:   off_c = {req_addr[1], 1'b0};
      default: off_c = 2'b00;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    case (req_size)
      2'b00:   err_c = 1'b0;
      2'b01:   err_c = req_addr[0];
      default: err_c = |req_addr[1:0];
    endcase
`else
    err_c = 1'b0;
`endif
    case (req_size)
      2'b00: begin
        be_c = 4'b0001 << off_c;
        wd_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c = off_c[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{req_wdata[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = req_wdata;
      end
    endcase
    wr_en_c   = accept_c & req_we & ~err_c;
    rd_word_c = mem[idx_c];
    sh_c      = rd_word_c >> {off_c, 3'b000};
    case (req_size)
      2'b00:   ld_c = {{24{~req_unsigned & sh_c[7]}}, sh_c[7:0]};
      2'b01:   ld_c = {{16{~req_unsigned & sh_c[15]}}, sh_c[15:0]};
      default: ld_c = sh_c;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    clr_cnt_nx   = clr_cnt;
    rsp_valid_nx = accept_c;
    rsp_rdata_nx = rsp_rdata;
    rsp_err_nx   = rsp_err;
    case (state)
      ST_INIT: begin
        clr_cnt_nx = clr_cnt + IDX_W'(1);
        if (clr_cnt == IDX_W'(DEPTH - 1)) state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
    req_ready_nx = (state_nx == ST_RUN);
    init_done_nx = (state_nx == ST_RUN);
    if (accept_c) begin
      rsp_err_nx   = err_c;
      rsp_rdata_nx = (req_we | err_c) ? 32'h0 : ld_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      clr_cnt   <= clr_cnt_nx;
      req_ready <= req_ready_nx;
      init_done <= init_done_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_err   <= rsp_err_nx;
    end
  end

  // Array: clear sweep while initialising, lane-masked stores afterwards.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[clr_cnt] <= 32'h0;
    end else if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[idx_c][8*b +: 8] <= wd_c[8*b +: 8];
      end
    end
  end

  // Address bits above the word index alias and are intentionally ignored.
  if (ADDR_W > IDX_W + 2) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: byte-array reference model, directed plan plus random traffic.
module tb_dmem_ctrl;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned NBYTES = 4 * DEPTH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  dmem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mem_b [NBYTES];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: memory as a flat byte array, accesses assembled byte by byte.
  function automatic void model(input bit we, input logic [1:0] sz, input bit uns,
                                input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int unsigned base, n;
    logic [31:0] v;
    base = int'(a) % NBYTES;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    rd   = 32'h0;
    err  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (base % n != 0) begin
      err = 1'b1;
      return;
    end
`endif
    base = base - (base % n);
    if (we) begin
      for (int i = 0; i < int'(n); i++) mem_b[base + i] = 8'(wd >> (8 * i));
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(n); i++) v = v | (32'(mem_b[base + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic clear_model();
    for (int i = 0; i < int'(NBYTES); i++) mem_b[i] = 8'h00;
  endtask

  task automatic req(input bit we, input logic [1:0] sz, input bit uns,
                     input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    exp_t e;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    model(we, sz, uns, a, wd, rd, er);
    e.cyc = cyc + 1; e.rdata = rd; e.err = er;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_addr = ADDR_W'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("init_cycles", 32'(n), 32'd32);
    check("init_done", 32'(init_done), 32'd1);
  endtask

  // Monitor: pops one expectation per response, checks latency, data and hold behaviour.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL spurious_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rsp_latency", 32'(cyc), 32'(e.cyc));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          last_rdata = e.rdata;
          last_err   = e.err;
        end
      end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
        vectors++; miscompares++;
        $display("FAIL missing_rsp: got rsp_valid=0 expected response due cycle %0d (t=%0t)",
                 sb_q[0].cyc, $time);
        void'(sb_q.pop_front());
      end else begin
        check("hold_rdata", rsp_rdata, last_rdata);
        check("hold_err", 32'(rsp_err), 32'(last_err));
      end
    end
  end

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0;
    clear_model();
    #3 rst_n = 1'b0;
    #1 mon_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    wait_init();

    // Directed plan
    req(1'b0, 2'd2, 1'b0, 11'h07C, 32'h0);
    req(1'b1, 2'd2, 1'b0, 11'h010, 32'h8899AABB);
    req(1'b0, 2'd2, 1'b0, 11'h010, 32'h0);
    req(1'b0, 2'd2, 1'b0, 11'h090, 32'h0);
    req(1'b1, 2'd0, 1'b0, 11'h011, 32'h000000FF);
    req(1'b0, 2'd0, 1'b0, 11'h011, 32'h0);
    req(1'b0, 2'd0, 1'b1, 11'h011, 32'h0);
    req(1'b0, 2'd2, 1'b0, 11'h010, 32'h0);
    idle();
    req(1'b0, 2'd1, 1'b0, 11'h012, 32'h0);
    req(1'b0, 2'd1, 1'b1, 11'h012, 32'h0);
    req(1'b1, 2'd1, 1'b0, 11'h012, 32'h00001234);
    req(1'b0, 2'd2, 1'b0, 11'h010, 32'h0);
    idle(); idle();
    req(1'b0, 2'd2, 1'b0, 11'h013, 32'h0);
    req(1'b1, 2'd2, 1'b0, 11'h013, 32'hDEADBEEF);
    req(1'b0, 2'd2, 1'b0, 11'h010, 32'h0);
    req(1'b0, 2'd3, 1'b1, 11'h7F1, 32'h0);
    idle();

    // Random traffic with idle gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ADDR_W'($urandom_range(0, 2047)), $urandom);
    end
    idle(); idle();

    // Reset with a load in flight
    req(1'b1, 2'd2, 1'b0, 11'h010, 32'hCAFEF00D);
    req(1'b0, 2'd2, 1'b0, 11'h010, 32'h0);
    @(posedge clk);
    #1 check("inflight_valid", 32'(rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    sb_q.delete();
    last_rdata = 32'h0;
    last_err = 1'b0;
    clear_model();
    #1 check("rst_drop_valid", 32'(rsp_valid), 32'd0);
    check("rst_drop_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    req(1'b0, 2'd2, 1'b0, 11'h010, 32'h0);
    for (int i = 0; i < 40; i++)
      req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ADDR_W'($urandom_range(0, 2047)), $urandom);
    idle(); idle(); idle();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
